// File: rtl/watch_time_reporter_pkg.sv
// Shared constants and types for the watch time reporter: ASCII codes,
// watch field widths, FSM encoding and small byte-formatting helpers.
package watch_time_reporter_pkg;

  localparam logic [7:0] ASC_0     = 8'h30;
  localparam logic [7:0] ASC_COLON = 8'h3A;
  localparam logic [7:0] ASC_DOT   = 8'h2E;
  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_LF    = 8'h0A;

  localparam int MSEC_W = 7;
  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // Index of the final byte of a message for a given build.
  function automatic logic [3:0] msg_last(input int send_centi, input int eol_crlf);
    return 4'(8 + ((send_centi != 0) ? 3 : 0) + ((eol_crlf != 0) ? 2 : 1) - 1);
  endfunction

  function automatic logic [7:0] digit(input logic [3:0] n);
    return ASC_0 + {4'h0, n};
  endfunction

endpackage

// File: rtl/watch_time_reporter_if.sv
// Request / time-field / TX byte bundle between the watch host side and the
// reporter.
interface watch_time_reporter_if;
  import watch_time_reporter_pkg::*;

  // TX handshake: a byte moves on any clock edge where o_tx_valid and
  // i_tx_ready are both 1. Once o_tx_valid rises, it and o_tx_data hold
  // steady until that transfer; i_tx_ready may stall for any length.
  logic              i_req;
  logic [MSEC_W-1:0] i_msec;
  logic [SEC_W-1:0]  i_sec;
  logic [MIN_W-1:0]  i_min;
  logic [HOUR_W-1:0] i_hour;
  logic [7:0]        o_tx_data;
  logic              o_tx_valid;
  logic              i_tx_ready;
  logic              o_busy;
  logic              o_done;

  modport master (
    output i_req, i_msec, i_sec, i_min, i_hour, i_tx_ready,
    input  o_tx_data, o_tx_valid, o_busy, o_done
  );

  modport slave (
    input  i_req, i_msec, i_sec, i_min, i_hour, i_tx_ready,
    output o_tx_data, o_tx_valid, o_busy, o_done
  );

endinterface

// File: rtl/watch_time_reporter_bin2dec_2d.sv
// 7-bit binary to two BCD digits, saturating at 99. Purely combinational.
module watch_time_reporter_bin2dec_2d (
  input  logic [6:0] bin,
  output logic [3:0] tens,
  output logic [3:0] units
);

  logic [6:0] sat;

  always_comb begin
    sat  = (bin > 7'd99) ? 7'd99 : bin;
    tens = 4'd0;
    for (int k = 1; k < 10; k++) begin
      if (sat >= 7'(k * 10)) tens = 4'(k);
    end
    units = 4'(sat - ({3'b000, tens} * 7'd10));
  end

endmodule

// File: rtl/watch_time_reporter.sv
// Snapshots the watch counters on request and streams "HH:MM:SS[.CC]\r?\n"
// one byte per handshake, queueing at most one extra request.
module watch_time_reporter
  import watch_time_reporter_pkg::*;
#(
  parameter int SEND_CENTI = 1,
  parameter int EOL_CRLF   = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  watch_time_reporter_if.slave   bus,
  output state_t                 dbg_state
);

  localparam logic [3:0] LAST_IDX = msg_last(SEND_CENTI, EOL_CRLF);
  localparam logic [3:0] EOL_POS  = 4'(8 + ((SEND_CENTI != 0) ? 3 : 0));
  localparam logic [3:0] EOL_POS1 = EOL_POS + 4'd1;

  logic [MSEC_W-1:0] snap_msec;
  logic [SEC_W-1:0]  snap_sec;
  logic [MIN_W-1:0]  snap_min;
  logic [HOUR_W-1:0] snap_hour;
  state_t            state;
  logic [3:0]        idx;
  logic              pending, tx_valid, busy, done;
  logic              xfer, last, capture;
  logic [3:0]        h1, h0, m1, m0, s1, s0, c1, c0;
  logic [7:0]        tab [16];

  watch_time_reporter_bin2dec_2d u_hour (.bin({2'b00, snap_hour}), .tens(h1), .units(h0));
  watch_time_reporter_bin2dec_2d u_min  (.bin({1'b0, snap_min}),   .tens(m1), .units(m0));
  watch_time_reporter_bin2dec_2d u_sec  (.bin({1'b0, snap_sec}),   .tens(s1), .units(s0));
  watch_time_reporter_bin2dec_2d u_msec (.bin(snap_msec),          .tens(c1), .units(c0));

  assign xfer    = tx_valid & bus.i_tx_ready;
  assign last    = (idx == LAST_IDX);
  // A fresh snapshot is taken on a new request from idle, or at the last
  // transfer when another request is queued or arrives on that same edge.
  assign capture = ((state == ST_IDLE) & bus.i_req)
                 | (xfer & last & (pending | bus.i_req));

  always_comb begin
    for (int i = 0; i < 16; i++) tab[i] = 8'h00;
    tab[0] = digit(h1);
    tab[1] = digit(h0);
    tab[2] = ASC_COLON;
    tab[3] = digit(m1);
    tab[4] = digit(m0);
    tab[5] = ASC_COLON;
    tab[6] = digit(s1);
    tab[7] = digit(s0);
    if (SEND_CENTI != 0) begin
      tab[8]  = ASC_DOT;
      tab[9]  = digit(c1);
      tab[10] = digit(c0);
    end
    if (EOL_CRLF != 0) begin
      tab[EOL_POS]  = ASC_CR;
      tab[EOL_POS1] = ASC_LF;
    end else begin
      tab[EOL_POS] = ASC_LF;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_msec <= '0;
      snap_sec  <= '0;
      snap_min  <= '0;
      snap_hour <= '0;
    end else if (capture) begin
      snap_msec <= bus.i_msec;
      snap_sec  <= bus.i_sec;
      snap_min  <= bus.i_min;
      snap_hour <= bus.i_hour;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      idx      <= 4'd0;
      pending  <= 1'b0;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.i_req) begin
            state    <= ST_SEND;
            idx      <= 4'd0;
            tx_valid <= 1'b1;
            busy     <= 1'b1;
          end
        end
        ST_SEND: begin
          if (xfer && last) begin
            done    <= 1'b1;
            idx     <= 4'd0;
            pending <= 1'b0;
            if (!(pending || bus.i_req)) begin
              state    <= ST_IDLE;
              tx_valid <= 1'b0;
              busy     <= 1'b0;
            end
          end else begin
            if (xfer) idx <= idx + 4'd1;
            if (bus.i_req) pending <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_tx_data  = tx_valid ? tab[idx] : 8'h00;
  assign bus.o_tx_valid = tx_valid;
  assign bus.o_busy     = busy;
  assign bus.o_done     = done;
  assign dbg_state      = state;

endmodule

// File: tb/tb_watch_time_reporter.sv
// Bench for watch_time_reporter: default build plus a 9-byte build, checked
// against an arithmetic model of the ASCII message.
module tb_watch_time_reporter;
  import watch_time_reporter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  watch_time_reporter_if bus ();
  watch_time_reporter_if bus9 ();
  state_t st, st9;

  watch_time_reporter dut (.clk(clk), .rst(rst), .bus(bus), .dbg_state(st));
  watch_time_reporter #(.SEND_CENTI(0), .EOL_CRLF(0)) dut9 (
    .clk(clk), .rst(rst), .bus(bus9), .dbg_state(st9)
  );

  int n_cmp = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] exp9_q[$];
  logic [7:0] got9_q[$];
  int done_cnt = 0;
  int busy_cnt = 0;
  logic stall_pend = 1'b0;
  logic [7:0] stall_data = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected message from the field values: tens = v/10, units = v%10,
  // centiseconds above 99 shown as 99.
  function automatic void push_model(input int h, input int m, input int s, input int c,
                                     input bit centi, input bit crlf, input bit sel9);
    logic [7:0] b[$];
    int cs;
    cs = (c > 99) ? 99 : c;
    b.push_back(8'(48 + h / 10)); b.push_back(8'(48 + h % 10)); b.push_back(8'h3A);
    b.push_back(8'(48 + m / 10)); b.push_back(8'(48 + m % 10)); b.push_back(8'h3A);
    b.push_back(8'(48 + s / 10)); b.push_back(8'(48 + s % 10));
    if (centi) begin
      b.push_back(8'h2E); b.push_back(8'(48 + cs / 10)); b.push_back(8'(48 + cs % 10));
    end
    if (crlf) b.push_back(8'h0D);
    b.push_back(8'h0A);
    foreach (b[i]) begin
      if (sel9) exp9_q.push_back(b[i]);
      else exp_q.push_back(b[i]);
    end
  endfunction

  always @(negedge clk) begin
    if (stall_pend) begin
      check("stall_valid", 32'(bus.o_tx_valid), 32'd1);
      check("stall_data", 32'(bus.o_tx_data), 32'(stall_data));
    end
    stall_pend = !rst && bus.o_tx_valid && !bus.i_tx_ready;
    stall_data = bus.o_tx_data;
    if (bus.o_tx_valid && bus.i_tx_ready) got_q.push_back(bus.o_tx_data);
    if (bus9.o_tx_valid && bus9.i_tx_ready) got9_q.push_back(bus9.o_tx_data);
    if (bus.o_done) done_cnt++;
    if (bus.o_busy) busy_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_time(input int h, input int m, input int s, input int c);
    bus.i_hour = 5'(h);
    bus.i_min  = 6'(m);
    bus.i_sec  = 6'(s);
    bus.i_msec = 7'(c);
  endtask

  task automatic pulse_req();
    bus.i_req = 1'b1;
    tick();
    bus.i_req = 1'b0;
  endtask

  task automatic check_msg(input string tag, input bit sel9);
    int n;
    if (sel9) begin
      check($sformatf("%s_len", tag), 32'(got9_q.size()), 32'(exp9_q.size()));
      n = (got9_q.size() < exp9_q.size()) ? got9_q.size() : exp9_q.size();
      for (int i = 0; i < n; i++)
        check($sformatf("%s_b%0d", tag, i), 32'(got9_q[i]), 32'(exp9_q[i]));
    end else begin
      check($sformatf("%s_len", tag), 32'(got_q.size()), 32'(exp_q.size()));
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
        check($sformatf("%s_b%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    end
  endtask

  task automatic send_msg(input string tag, input int h, input int m, input int s,
                          input int c, input bit stalls, input bit roll);
    got_q.delete();
    exp_q.delete();
    push_model(h, m, s, c, 1'b1, 1'b1, 1'b0);
    set_time(h, m, s, c);
    bus.i_tx_ready = 1'b1;
    pulse_req();
    for (int k = 0; k < 600 && !bus.o_done; k++) begin
      if (stalls) bus.i_tx_ready = 1'($urandom_range(0, 1));
      if (roll && k == 4) set_time(0, 0, 0, 0);
      tick();
    end
    check($sformatf("%s_done", tag), 32'(bus.o_done), 32'd1);
    bus.i_tx_ready = 1'b1;
    tick();
    check_msg(tag, 1'b0);
  endtask

  initial begin
    bus.i_req = 1'b0;  bus.i_tx_ready = 1'b1;  set_time(0, 0, 0, 0);
    bus9.i_req = 1'b0; bus9.i_tx_ready = 1'b1;
    bus9.i_hour = 5'd12; bus9.i_min = 6'd34; bus9.i_sec = 6'd56; bus9.i_msec = 7'd78;

    // Reset and idle
    repeat (3) tick();
    check("rst_valid", 32'(bus.o_tx_valid), 32'd0);
    check("rst_data", 32'(bus.o_tx_data), 32'h00);
    rst = 1'b0;
    repeat (2) tick();
    check("idle_valid", 32'(bus.o_tx_valid), 32'd0);
    check("idle_busy", 32'(bus.o_busy), 32'd0);
    check("idle_done", 32'(bus.o_done), 32'd0);
    check("idle_data", 32'(bus.o_tx_data), 32'h00);
    check("idle_state", 32'(st), 32'(ST_IDLE));
    check("idle9_valid", 32'(bus9.o_tx_valid), 32'd0);

    // 12:34:56.78 with ready held: one byte per cycle, exact timing
    got_q.delete(); exp_q.delete();
    push_model(12, 34, 56, 78, 1'b1, 1'b1, 1'b0);
    set_time(12, 34, 56, 78);
    busy_cnt = 0; done_cnt = 0;
    pulse_req();
    check("t2_state", 32'(st), 32'(ST_SEND));
    check("t2_first", 32'(bus.o_tx_data), 32'h31);
    for (int i = 0; i < 13; i++) begin
      check($sformatf("t2_valid%0d", i), 32'(bus.o_tx_valid), 32'd1);
      check($sformatf("t2_nodone%0d", i), 32'(bus.o_done), 32'd0);
      tick();
    end
    check("t2_done", 32'(bus.o_done), 32'd1);
    check("t2_busy_off", 32'(bus.o_busy), 32'd0);
    check("t2_valid_off", 32'(bus.o_tx_valid), 32'd0);
    tick();
    check("t2_done_pulse", 32'(bus.o_done), 32'd0);
    check("t2_busy_cnt", 32'(busy_cnt), 32'd13);
    check_msg("t2", 1'b0);

    // Roll-over mid-message with random stalls
    send_msg("t3", 23, 59, 59, 99, 1'b1, 1'b1);

    // Saturation of centiseconds
    send_msg("t4", 0, 0, 0, 120, 1'b0, 1'b0);

    // Randomized fields over the full input widths
    for (int r = 0; r < 4; r++)
      send_msg($sformatf("rnd%0d", r), $urandom_range(0, 31), $urandom_range(0, 63),
               $urandom_range(0, 63), $urandom_range(0, 127), 1'b1, 1'b0);

    // Three requests during a message: exactly one queued restart
    got_q.delete(); exp_q.delete();
    push_model(1, 2, 3, 4, 1'b1, 1'b1, 1'b0);
    push_model(5, 6, 7, 8, 1'b1, 1'b1, 1'b0);
    set_time(1, 2, 3, 4);
    busy_cnt = 0; done_cnt = 0;
    pulse_req();
    set_time(5, 6, 7, 8);
    for (int k = 0; k < 12; k++) begin
      bus.i_req = (k == 2 || k == 4 || k == 6);
      tick();
    end
    bus.i_req = 1'b0;
    for (int k = 0; k < 100 && done_cnt < 2; k++) tick();
    repeat (3) tick();
    check("t5_done_cnt", 32'(done_cnt), 32'd2);
    check("t5_busy_cnt", 32'(busy_cnt), 32'd26);
    check("t5_idle", 32'(bus.o_tx_valid), 32'd0);
    check_msg("t5", 1'b0);

    // Reset after five bytes, then a complete message
    got_q.delete();
    set_time(12, 34, 56, 78);
    pulse_req();
    repeat (5) tick();
    check("t6_mid_valid", 32'(bus.o_tx_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("t6_rst_valid", 32'(bus.o_tx_valid), 32'd0);
    check("t6_rst_busy", 32'(bus.o_busy), 32'd0);
    check("t6_rst_data", 32'(bus.o_tx_data), 32'h00);
    tick();
    rst = 1'b0;
    tick();
    send_msg("t6", 12, 34, 56, 78, 1'b0, 1'b0);

    // Short build: no centiseconds, LF only
    got9_q.delete(); exp9_q.delete();
    push_model(12, 34, 56, 78, 1'b0, 1'b0, 1'b1);
    bus9.i_req = 1'b1;
    tick();
    bus9.i_req = 1'b0;
    for (int k = 0; k < 100 && !bus9.o_done; k++) tick();
    check("t7_done", 32'(bus9.o_done), 32'd1);
    tick();
    check("t7_state", 32'(st9), 32'(ST_IDLE));
    check_msg("t7", 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
